ssd_display_ctrl: RTL

SSD_DISPLAY_CTRL -- requirements
Module: ssd_display_ctrl

---
 rtl/ssd_display_ctrl_if.sv | 11 +
 rtl/ssd_display_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/ssd_display_ctrl_if.sv
// Conversion request/result bundle between a producer of numbers and ssd_display_ctrl.
interface ssd_display_ctrl_if;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        done;
    logic [15:0] digits;

    modport master (output value, load, input busy, done, digits);
    modport slave  (input value, load, output busy, done, digits);
endinterface

// File: rtl/ssd_display_ctrl.sv
// Signed 14-bit to 4-digit seven-segment code converter with free-running scan strobe.
// Optional macro SSD_LZB_EN: blank leading zeros and float the minus sign to the leftmost digit.
module ssd_display_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    ssd_display_ctrl_if.slave   bus,
    output logic                scan_tick
);

    typedef enum logic [2:0] {IDLE, ABS, SHIFT, FORMAT, DONE} state_t;

    localparam logic [16:0] SCAN_LAST = 17'(SCAN_DIV - 1);

    state_t      state, state_nxt;
    logic [13:0] value_q;
    logic        sign_q;
    logic [29:0] sr_q;
    logic [29:0] sr_step;
    logic [3:0]  iter_q;
    logic [15:0] digits_q;
    logic [15:0] word;
    logic [16:0] scan_cnt;
    logic [13:0] mag;

    // Two's-complement negate; -8192 yields 14'h2000, read back as unsigned 8192.
    assign mag = value_q[13] ? (~value_q + 14'd1) : value_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load) state_nxt = ABS;
            ABS:     state_nxt = SHIFT;
            SHIFT:   if (iter_q == 4'd13) state_nxt = FORMAT;
            FORMAT:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One double-dabble iteration: correct each BCD nibble, then shift.
    always_comb begin
        logic [29:0] adj;
        adj = sr_q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (adj[14 + 4*k +: 4] >= 4'd5)
                adj[14 + 4*k +: 4] = adj[14 + 4*k +: 4] + 4'd3;
        end
        sr_step = {adj[28:0], 1'b0};
    end

    always_comb begin
        logic [3:0] d3, d2, d1;
        d3   = sr_q[29:26];
        d2   = sr_q[25:22];
        d1   = sr_q[21:18];
        word = sr_q[29:14];
        if (sign_q && d3 != 4'd0) begin
            word = 16'hAAAA;
        end else begin
`ifdef SSD_LZB_EN
            if (d3 == 4'd0)                             word[15:12] = 4'hB;
            if (d3 == 4'd0 && d2 == 4'd0)               word[11:8]  = 4'hB;
            if (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) word[7:4]   = 4'hB;
            if (sign_q) begin
                if (d2 != 4'd0)      word[15:12] = 4'hA;
                else if (d1 != 4'd0) word[11:8]  = 4'hA;
                else                 word[7:4]   = 4'hA;
            end
`else
            if (sign_q) word[15:12] = 4'hA;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            value_q  <= '0;
            sign_q   <= 1'b0;
            sr_q     <= '0;
            iter_q   <= '0;
            digits_q <= 16'hBBBB;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.load) value_q <= bus.value;
                ABS: begin
                    sign_q <= value_q[13];
                    sr_q   <= {16'd0, mag};
                    iter_q <= '0;
                end
                SHIFT: begin
                    sr_q   <= sr_step;
                    iter_q <= iter_q + 4'd1;
                end
                FORMAT:  digits_q <= word;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || scan_cnt == SCAN_LAST) scan_cnt <= '0;
        else                              scan_cnt <= scan_cnt + 17'd1;
    end

    assign scan_tick  = (scan_cnt == SCAN_LAST);
    assign bus.busy   = (state != IDLE) && (state != DONE);
    assign bus.done   = (state == DONE);
    assign bus.digits = digits_q;

endmodule
